// File: rtl/seq_alu_pkg.sv
// Shared op-code and FSM encodings for seq_alu and its divider.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_DIV   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SHRA  = 4'd7,
    OP_SHL   = 4'd8,
    OP_ROR   = 4'd9,
    OP_ROL   = 4'd10,
    OP_NEG   = 4'd11,
    OP_NOT   = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu_nr_div_core.sv
// nr_div_core: signed non-restoring divider, one quotient bit per clock (built with SEQ_ALU_DIV_EN).
// done marks the final iteration; quotient/remainder are settled from the following cycle.
`ifdef SEQ_ALU_DIV_EN
module nr_div_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0]        dvd, dvs, rem_mag;
  logic signed [WIDTH+1:0] p, p_shl, p_nxt;
  logic [SHW-1:0]          cnt;
  logic                    run, q_neg, r_neg;

  // Partial remainder stays in [-dvs, dvs), so dropping p's top (sign-copy) bit is safe.
  assign p_shl = {p[WIDTH:0], dvd[WIDTH-1]};
  assign p_nxt = p[WIDTH+1] ? p_shl + {2'b00, dvs} : p_shl - {2'b00, dvs};
  assign done  = run && (cnt == SHW'(WIDTH-1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (start) begin
      // Magnitudes as unsigned: |MIN| = 2^(WIDTH-1) still fits.
      dvd   <= a[WIDTH-1] ? '0 - a : a;
      dvs   <= b[WIDTH-1] ? '0 - b : b;
      p     <= '0;
      cnt   <= '0;
      run   <= 1'b1;
      q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg <= a[WIDTH-1];
    end else if (run) begin
      p   <= p_nxt;
      dvd <= {dvd[WIDTH-2:0], ~p_nxt[WIDTH+1]};
      cnt <= cnt + SHW'(1);
      if (done) run <= 1'b0;
    end
  end

  assign rem_mag   = p[WIDTH+1] ? p[WIDTH-1:0] + dvs : p[WIDTH-1:0];
  assign quotient  = q_neg ? '0 - dvd : dvd;
  assign remainder = r_neg ? '0 - rem_mag : rem_mag;

endmodule
`endif

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, radix-4 Booth multiply inline, non-restoring divide in nr_div_core.
// Define SEQ_ALU_DIV_EN to build the divider; without it op DIV completes as illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               dz,
  output logic               ill
);
  state_e                  state, state_nxt;
  op_e                     op_r;
  logic [WIDTH-1:0]        a_r, b_r, mq, simple;
  logic                    accept, mul_last, mq_1, dz_fin, ill_fin;
  logic [SHW-1:0]          cnt, sh;
  logic signed [WIDTH+1:0] acc, mcand, booth_add, booth_sum;
  logic [2*WIDTH-1:0]      res_fin;

  assign accept   = start && (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign mul_last = (cnt == SHW'(WIDTH/2-1));

`ifdef SEQ_ALU_DIV_EN
  logic             div_go, div_done;
  logic [WIDTH-1:0] div_q, div_r;

  // Divide-by-zero never starts the engine; it completes like a simple op.
  assign div_go = accept && (op == OP_DIV) && (b != '0);

  nr_div_core #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (div_go),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) begin
        if (op == OP_MUL) state_nxt = S_MUL;
`ifdef SEQ_ALU_DIV_EN
        else if (div_go) state_nxt = S_DIV;
`endif
        else state_nxt = S_DONE;
      end
      S_MUL:  if (mul_last) state_nxt = S_DONE;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:  if (div_done) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Booth recoding of {mq[1:0], mq_1}: digit in {-2..+2} times the multiplicand.
  assign mcand = {{2{a_r[WIDTH-1]}}, a_r};
  always_comb begin
    case ({mq[1:0], mq_1})
      3'b001, 3'b010: booth_add = mcand;
      3'b011:         booth_add = mcand <<< 1;
      3'b100:         booth_add = -(mcand <<< 1);
      3'b101, 3'b110: booth_add = -mcand;
      default:        booth_add = '0;
    endcase
    booth_sum = acc + booth_add;
  end

  assign sh = b_r[SHW-1:0];
  always_comb begin
    case (op_r)
      OP_AND:  simple = a_r & b_r;
      OP_OR:   simple = a_r | b_r;
      OP_ADD:  simple = a_r + b_r;
      OP_SUB:  simple = a_r - b_r;
      OP_SHR:  simple = a_r >> sh;
      OP_SHRA: simple = $signed(a_r) >>> sh;
      OP_SHL:  simple = a_r << sh;
      OP_ROR:  simple = (a_r >> sh) | (a_r << (WIDTH - sh));
      OP_ROL:  simple = (a_r << sh) | (a_r >> (WIDTH - sh));
      OP_NEG:  simple = '0 - a_r;
      OP_NOT:  simple = ~a_r;
      default: simple = '0;
    endcase
  end

  always_comb begin
    res_fin = {{WIDTH{1'b0}}, simple};
    dz_fin  = 1'b0;
    ill_fin = (op_r > OP_LAST_LEGAL);
`ifdef SEQ_ALU_DIV_EN
    if (op_r == OP_DIV) begin
      dz_fin  = (b_r == '0);
      res_fin = dz_fin ? {a_r, {WIDTH{1'b1}}} : {div_r, div_q};
    end
`else
    if (op_r == OP_DIV) ill_fin = 1'b1;
`endif
    if (op_r == OP_MUL) res_fin = {acc[WIDTH-1:0], mq};
    if (ill_fin)        res_fin = '0;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_r   <= OP_AND;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      mq_1   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      dz     <= 1'b0;
      ill    <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (accept) begin
        op_r <= op_e'(op);
        a_r  <= a;
        b_r  <= b;
        cnt  <= '0;
        acc  <= '0;
        mq   <= b;
        mq_1 <= 1'b0;
      end else if (state == S_MUL) begin
        cnt  <= cnt + SHW'(1);
        acc  <= booth_sum >>> 2;
        mq   <= {booth_sum[1:0], mq[WIDTH-1:2]};
        mq_1 <= mq[1];
      end
      // result/flags only move on the edge that raises done
      if (state == S_DONE) begin
        result <= res_fin;
        dz     <= dz_fin;
        ill    <= ill_fin;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32), random and directed ops against an arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  logic          clock = 1'b0, clear_n = 1'b0, start = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, dz, ill;
  logic [2*W-1:0] result;
  int total = 0, bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .dz(dz), .ill(ill)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    logic        ill;
    int          lat;
  } exp_t;

  function automatic exp_t model(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    exp_t   e;
    int     s;
    longint sx, sy;
    s  = int'(y[4:0]);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (o)
      4'd0:  e.res[31:0] = x & y;
      4'd1:  e.res[31:0] = x | y;
      4'd2:  e.res[31:0] = x + y;
      4'd3:  e.res[31:0] = x - y;
      4'd4:  begin e.res = sx * sy; e.lat = W/2 + 1; end
      4'd5: begin
`ifdef SEQ_ALU_DIV_EN
        if (y == 0) begin e.res = {x, 32'hFFFF_FFFF}; e.dz = 1'b1; end
        else begin e.res = {32'(sx % sy), 32'(sx / sy)}; e.lat = W + 1; end
`else
        e.ill = 1'b1;
`endif
      end
      4'd6:  e.res[31:0] = x >> s;
      4'd7:  e.res[31:0] = $signed(x) >>> s;
      4'd8:  e.res[31:0] = x << s;
      4'd9:  e.res[31:0] = (x >> s) | (x << (32 - s));
      4'd10: e.res[31:0] = (x << s) | (x >> (32 - s));
      4'd11: e.res[31:0] = 32'd0 - x;
      4'd12: e.res[31:0] = ~x;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one op, scramble inputs after acceptance, wait for done (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] r, output logic z, output logic il, output int lat);
    @(negedge clock); start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    repeat (100) begin
      @(posedge clock); #1; lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    r = result; z = dz; il = ill;
  endtask

  task automatic test_reset;
    int seen;
    #12;
    total++;
    if ({busy, done, dz, ill, result} !== '0) begin
      bad++; $display("FAIL reset_hold: got %h want 0", {busy, done, dz, ill, result});
    end
    @(negedge clock); clear_n = 1'b1;
    repeat (3) @(posedge clock);
    #1; total++;
    if ({busy, done, result} !== '0) begin
      bad++; $display("FAIL reset_release: got %h want 0", {busy, done, result});
    end
    @(negedge clock); start = 1'b1; op = 4'd4; a = 32'd1234; b = 32'd5678;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    #2; clear_n = 1'b0;
    #1; total++;
    if ({busy, done, dz, ill, result} !== '0) begin
      bad++; $display("FAIL reset_mid_mul: got %h want 0", {busy, done, dz, ill, result});
    end
    @(negedge clock); clear_n = 1'b1;
    seen = 0;
    repeat (25) begin @(posedge clock); #1; if (done || busy) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_no_done: got %0d busy/done cycles want 0", seen); end
  endtask

  task automatic test_simple;
    logic [3:0]  vo[6] = '{4'd2, 4'd3, 4'd7, 4'd9, 4'd10, 4'd11};
    logic [31:0] va[6] = '{32'd12, 32'd32, 32'h8000_0008, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF8};
    logic [31:0] vb[6] = '{32'd28, 32'd20, 32'd2, 32'd1, 32'd33, 32'd0};
    logic [31:0] vx[6] = '{32'd40, 32'd12, 32'hE000_0002, 32'h7FFF_FFFE, 32'd8, 32'd8};
    logic [3:0]  pool[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [63:0] r; logic z, il; int lat; exp_t e; logic [3:0] o; logic [31:0] x, y;
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], r, z, il, lat);
      total++;
      if ({r, z, il, lat} !== {32'd0, vx[i], 1'b0, 1'b0, 32'd1}) begin
        bad++; $display("FAIL simple_dir[%0d]: got r=%h lat=%0d want r=%h lat=1", i, r, lat, vx[i]);
      end
    end
    for (int i = 0; i < 25; i++) begin
      o = pool[$urandom_range(0, 10)]; x = $urandom; y = $urandom;
      e = model(o, x, y);
      run_op(o, x, y, r, z, il, lat);
      total++;
      if ({r, z, il} !== {e.res, e.dz, e.ill} || lat != e.lat) begin
        bad++; $display("FAIL simple_rnd[%0d] op=%0d: got r=%h lat=%0d want r=%h lat=%0d", i, o, r, lat, e.res, e.lat);
      end
    end
  endtask

  task automatic test_mul;
    logic [31:0] va[3] = '{32'd3, 32'hFFFF_FFFD, 32'h7FFF_FFFF};
    logic [31:0] vb[3] = '{32'd4, 32'd4, 32'h7FFF_FFFF};
    logic [63:0] vx[3] = '{64'd12, 64'hFFFF_FFFF_FFFF_FFF4, 64'h3FFF_FFFF_0000_0001};
    logic [63:0] r; logic z, il; int lat, seen; exp_t e; logic [31:0] x, y;
    for (int i = 0; i < 3; i++) begin
      run_op(4'd4, va[i], vb[i], r, z, il, lat);
      total++;
      if (r !== vx[i] || lat != 17 || z !== 1'b0 || il !== 1'b0) begin
        bad++; $display("FAIL mul_dir[%0d]: got r=%h lat=%0d want r=%h lat=17", i, r, lat, vx[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom;
      if (i == 0) x = 32'h8000_0000;
      if (i == 1) y = 32'h8000_0000;
      e = model(4'd4, x, y);
      run_op(4'd4, x, y, r, z, il, lat);
      total++;
      if (r !== e.res || lat != e.lat) begin
        bad++; $display("FAIL mul_rnd[%0d]: got r=%h lat=%0d want r=%h lat=%0d", i, r, lat, e.res, e.lat);
      end
    end
    // start pulse while busy must be dropped, not queued
    x = $urandom; y = $urandom; e = model(4'd4, x, y);
    @(negedge clock); start = 1'b1; op = 4'd4; a = x; b = y;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock); start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    @(negedge clock); start = 1'b0;
    lat = 5;
    repeat (100) begin @(posedge clock); #1; lat++; if (done) break; end
    if (!done) lat = -1;
    total++;
    if (result !== e.res || lat != 17) begin
      bad++; $display("FAIL mul_busy_ignore: got r=%h lat=%0d want r=%h lat=17", result, lat, e.res);
    end
    seen = 0;
    repeat (5) begin @(posedge clock); #1; if (done || busy) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mul_no_queue: got %0d busy/done cycles want 0", seen); end
  endtask

  task automatic test_div;
    logic [63:0] r; logic z, il; int lat; exp_t e; logic [31:0] x, y;
`ifdef SEQ_ALU_DIV_EN
    logic [31:0] va[4] = '{32'd24, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] vb[4] = '{32'd12, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] vx[4] = '{64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD,
                           64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF};
    int          vl[4] = '{33, 33, 33, 1};
    logic        vz[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(4'd5, va[i], vb[i], r, z, il, lat);
      total++;
      if (r !== vx[i] || lat != vl[i] || z !== vz[i] || il !== 1'b0) begin
        bad++; $display("FAIL div_dir[%0d]: got r=%h dz=%b lat=%0d want r=%h dz=%b lat=%0d", i, r, z, lat, vx[i], vz[i], vl[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) y = 32'd0 - y;
      e = model(4'd5, x, y);
      run_op(4'd5, x, y, r, z, il, lat);
      total++;
      if ({r, z, il} !== {e.res, e.dz, e.ill} || lat != e.lat) begin
        bad++; $display("FAIL div_rnd[%0d]: got r=%h dz=%b lat=%0d want r=%h dz=%b lat=%0d", i, r, z, lat, e.res, e.dz, e.lat);
      end
    end
`else
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = (i == 0) ? 32'd0 : $urandom;
      run_op(4'd5, x, y, r, z, il, lat);
      total++;
      if ({r, z, il} !== {64'd0, 1'b0, 1'b1} || lat != 1) begin
        bad++; $display("FAIL div_off[%0d]: got r=%h dz=%b ill=%b lat=%0d want r=0 dz=0 ill=1 lat=1", i, r, z, il, lat);
      end
    end
`endif
  endtask

  task automatic test_illegal;
    logic [63:0] r; logic z, il; int lat;
    for (int i = 13; i < 16; i++) begin
      run_op(4'(i), $urandom, $urandom, r, z, il, lat);
      total++;
      if ({r, z, il} !== {64'd0, 1'b0, 1'b1} || lat != 1) begin
        bad++; $display("FAIL illegal[%0d]: got r=%h dz=%b ill=%b lat=%0d want r=0 dz=0 ill=1 lat=1", i, r, z, il, lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y, x2, y2; exp_t em, ea; int lat;
    x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
    em = model(4'd4, x, y); ea = model(4'd2, x2, y2);
    @(negedge clock); start = 1'b1; op = 4'd4; a = x; b = y;
    @(posedge clock); #1; op = 4'd2; a = x2; b = y2;
    lat = 0;
    repeat (100) begin @(posedge clock); #1; lat++; if (done) break; end
    if (!done) lat = -1;
    total++;
    if (result !== em.res || lat != 17 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_mul: got r=%h lat=%0d busy=%b want r=%h lat=17 busy=0", result, lat, busy, em.res);
    end
    @(posedge clock); #1;
    total++;
    if ({busy, done} !== 2'b10 || result !== em.res) begin
      bad++; $display("FAIL b2b_accept: got busy=%b done=%b r=%h want busy=1 done=0 r=%h", busy, done, result, em.res);
    end
    start = 1'b0;
    @(posedge clock); #1;
    total++;
    if (done !== 1'b1 || result !== ea.res) begin
      bad++; $display("FAIL b2b_add: got done=%b r=%h want done=1 r=%h", done, result, ea.res);
    end
    @(posedge clock); #1;
    total++;
    if (done !== 1'b0 || result !== ea.res) begin
      bad++; $display("FAIL b2b_hold: got done=%b r=%h want done=0 r=%h", done, result, ea.res);
    end
  endtask

  task automatic test_random;
    logic [63:0] r; logic z, il; int lat; exp_t e; logic [3:0] o; logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15)); x = $urandom; y = $urandom;
      if (i % 7 == 0) y = 32'd0;
      e = model(o, x, y);
      run_op(o, x, y, r, z, il, lat);
      total++;
      if ({r, z, il} !== {e.res, e.dz, e.ill} || lat != e.lat) begin
        bad++; $display("FAIL random[%0d] op=%0d: got r=%h dz=%b ill=%b lat=%0d want r=%h dz=%b ill=%b lat=%0d",
                        i, o, r, z, il, lat, e.res, e.dz, e.ill, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the datapath, the successor to the combinational `ALU`. It keeps the same 13-op encoding and the 2×WIDTH result bus. Multiply runs as an iterative radix-4 Booth engine and divide as an iterative non-restoring engine, so neither sits in the critical path. A start/busy/done handshake lets the control unit stall while a multi-cycle op runs.

## Interface
- `WIDTH`, 32, operand width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override).
- `clock`  in  1  rising-edge clock.
- `clear_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT, 13–15 illegal.
- `a`, `b`  in  WIDTH  operands, captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until `done`.
- `done`  out  1  one-cycle pulse; `result`/flags valid from this cycle on.
- `result`  out  2*WIDTH  result, held until the next accepted `start`.
- `dz`  out  1  divide-by-zero, valid with `done`.
- `ill`  out  1  illegal op, or DIV when compiled out; valid with `done`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE with `start`=1: latch `a`, `b`, `op`; set `busy`.
  - MUL or DIV op goes to the matching state. Every other op goes straight to DONE with its result registered.
  - MUL: WIDTH/2 iterations, then DONE. DIV: WIDTH iterations, then DONE.
  - DONE: pulse `done`, clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored and is not queued. `op`, `a` and `b` changing mid-operation have no effect.
- Simple ops write `result[WIDTH-1:0]`; `result[2WIDTH-1:WIDTH]` = 0.
  - ADD/SUB wrap modulo 2^WIDTH.
  - NEG = 0 − a. NOT = ~a.
  - Shifts and rotates use `b[SHW-1:0]` (amount mod WIDTH). SHRA replicates `a[WIDTH-1]`.
- MUL: signed × signed. `result` = full 2×WIDTH two's-complement product.
- DIV: signed, truncates toward zero. `result` = {remainder, quotient}; remainder takes the dividend's sign.
  - Special case: `b`=0 skips iteration, goes to DONE next cycle with quotient = all ones, remainder = `a`, `dz`=1.
  - Special case: `a`=MIN, `b`=−1 gives quotient = MIN, remainder = 0, `dz`=0.
- Illegal op: `result`=0, `ill`=1, single-cycle.
- Reset (any time, including mid-MUL/DIV): state IDLE, `busy`=0, `done`=0, `result`=0, `dz`=0, `ill`=0. The partial operation is discarded.

## Timing
- Latency counts edges after the edge that samples `start`=1 as edge 0.
- Simple/illegal/div-by-zero: `done`=1 after edge 1.
- MUL: `done` after edge WIDTH/2+1 (17 at WIDTH=32).
- DIV: `done` after edge WIDTH+1 (33 at WIDTH=32).
- Back-to-back: `start` may be asserted in the `done` cycle. It is accepted on the next edge, when the FSM is in IDLE; throughput is one op per latency+1 edges.
- `result` changes only on the edge that raises `done`, and on reset.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV engine and DIV state are built, with behaviour as above.
- `SEQ_ALU_DIV_EN` undefined: no divider hardware. Op 5 is treated as illegal: `result`=0, `ill`=1, single-cycle; `dz` is tied to 0.

## Structure
- `seq_alu_pkg` holds:
  - the op-code localparams/enum (0–15 names),
  - the FSM state enum,
  - the `OP_LAST_LEGAL`=12 constant.
- Sub-module `nr_div_core`: the non-restoring iterative divider, wrapped in the `SEQ_ALU_DIV_EN` guard.
  - It takes start/operands and returns quotient, remainder and done.
  - It handles sign fix-up internally.
- The Booth multiplier, shifter and logic stay inline in `seq_alu`.

## Test plan
All vectors use WIDTH=32.
- Reset: hold `clear_n`=0, then release. Then hold `clear_n`=0 mid-MUL. → all outputs 0, state IDLE, no `done` after release.
- Simple ops:
  - ADD 12+28 → `result`=40.
  - SUB 32−20 → 12.
  - SHRA 0x80000008 by 2 → 0xE0000002.
  - ROR 0xFFFFFFFC by 1 → 0x7FFFFFFE.
  - ROL 4 by 33 → 8.
  - NEG −8 → 8.
  - Each shows `done` one edge after `start`, with upper half 0.
- MUL:
  - 3×4 → 12.
  - −3×4 → 0xFFFFFFFF_FFFFFFF4.
  - 0x7FFFFFFF² → 0x3FFFFFFF_00000001.
  - `done` exactly 17 edges after accept; a `start` pulse during `busy` is ignored.
- DIV (`SEQ_ALU_DIV_EN` on):
  - 24/12 → {0,2}.
  - −7/2 → {−1,−3}.
  - MIN/−1 → {0,MIN}.
  - 5/0 → {5,0xFFFFFFFF}, `dz`=1, `done` after 1 edge.
  - Normal divides show `done` at 33 edges.
- DIV (`SEQ_ALU_DIV_EN` off), and op 13 → `result`=0, `ill`=1, `done` after 1 edge.
- Back-to-back: MUL then ADD, with the ADD `start` held through `done` → ADD accepted on the edge after `done`; each result is held until its successor's `done`.
